// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the two-port data memory arbiter: both requester ports,
// the single-ported memory command/response path and the status outputs.
interface dmem_arbiter_if;
  logic        req0;
  logic        we0;
  logic [15:0] addr0;
  logic [15:0] wdata0;
  logic        ack0;
  logic [15:0] rdata0;
  logic        err0;

  logic        req1;
  logic        we1;
  logic [15:0] addr1;
  logic [15:0] wdata1;
  logic        ack1;
  logic [15:0] rdata1;
  logic        err1;

  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;

  logic        busy;
  logic [7:0]  err_count;

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_read_data,
    output ack0, rdata0, err0,
    output ack1, rdata1, err1,
    output mem_read, mem_write, mem_address, mem_write_data,
    output busy, err_count
  );

  // Requester / memory side.
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_read_data,
    input  ack0, rdata0, err0,
    input  ack1, rdata1, err1,
    input  mem_read, mem_write, mem_address, mem_write_data,
    input  busy, err_count
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory.
// Port 0 is the CPU load/store unit, port 1 the DMA/debug engine.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a request; grants one port and latches its command
// ISSUE   | one-cycle mem_read/mem_write pulse with the latched address/data
// CAPTURE | registered memory read data arrives; copy into granted rdata
// ACK     | one-cycle acknowledge to the granted port, no new grant
//
// The memory command is registered at grant time, so the mem_* registers
// themselves hold the latched address and write data during ISSUE.
// Out-of-window requests skip ISSUE/CAPTURE and go straight to ACK with err.
module dmem_arbiter #(
  parameter bit         ROUND_ROBIN = 1'b1,
  parameter logic [3:0] DMEM_NIBBLE = 4'h1
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t      state;
  logic        gnt;
  logic        last_grant;
  logic        we_q;

  logic        ack0_q, ack1_q;
  logic        err0_q, err1_q;
  logic [15:0] rdata0_q, rdata1_q;
  logic        mem_read_q, mem_write_q;
  logic [15:0] mem_address_q, mem_write_data_q;
  logic        busy_q;
  logic [7:0]  err_count_q;

  logic        win;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_legal;

  // Choose the winner among live requests and mux its command; only consumed in IDLE.
  always_comb begin
    win = 1'b0;
    if (bus.req0 && bus.req1) begin
      win = ROUND_ROBIN ? ~last_grant : 1'b0;
    end else if (bus.req1) begin
      win = 1'b1;
    end
    sel_we    = win ? bus.we1    : bus.we0;
    sel_addr  = win ? bus.addr1  : bus.addr0;
    sel_wdata = win ? bus.wdata1 : bus.wdata0;
    sel_legal = (sel_addr[15:12] == DMEM_NIBBLE);
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      gnt              <= 1'b0;
      last_grant       <= 1'b1;
      we_q             <= 1'b0;
      ack0_q           <= 1'b0;
      ack1_q           <= 1'b0;
      err0_q           <= 1'b0;
      err1_q           <= 1'b0;
      rdata0_q         <= 16'h0000;
      rdata1_q         <= 16'h0000;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= 16'h0000;
      mem_write_data_q <= 16'h0000;
      busy_q           <= 1'b0;
      err_count_q      <= 8'h00;
    end else begin
      // Pulsed outputs default low; only the cycle that needs them raises them.
      ack0_q           <= 1'b0;
      ack1_q           <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= 16'h0000;
      mem_write_data_q <= 16'h0000;

      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt        <= win;
            we_q       <= sel_we;
            last_grant <= win;
            busy_q     <= 1'b1;
            if (sel_legal) begin
              state            <= ISSUE;
              mem_read_q       <= ~sel_we;
              mem_write_q      <= sel_we;
              mem_address_q    <= sel_addr;
              mem_write_data_q <= sel_wdata;
            end else begin
              state <= ACK;
              if (win) begin
                ack1_q   <= 1'b1;
                err1_q   <= 1'b1;
                rdata1_q <= 16'h0000;
              end else begin
                ack0_q   <= 1'b1;
                err0_q   <= 1'b1;
                rdata0_q <= 16'h0000;
              end
              if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
              end
            end
          end
        end

        ISSUE: begin
          state <= CAPTURE;
        end

        CAPTURE: begin
          state <= ACK;
          if (gnt) begin
            ack1_q   <= 1'b1;
            err1_q   <= 1'b0;
            rdata1_q <= we_q ? 16'h0000 : bus.mem_read_data;
          end else begin
            ack0_q   <= 1'b1;
            err0_q   <= 1'b0;
            rdata0_q <= we_q ? 16'h0000 : bus.mem_read_data;
          end
        end

        ACK: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack0           = ack0_q;
  assign bus.ack1           = ack1_q;
  assign bus.err0           = err0_q;
  assign bus.err1           = err1_q;
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.busy           = busy_q;
  assign bus.err_count      = err_count_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle
// corner sequences, and a randomized phase against a transaction-level model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic mem_clear;

  always #5 clk = ~clk;

  dmem_arbiter_if bus_a ();
  dmem_arbiter_if bus_b ();

  dmem_arbiter #(.ROUND_ROBIN(1'b1), .DMEM_NIBBLE(4'h1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  dmem_arbiter #(.ROUND_ROBIN(1'b0), .DMEM_NIBBLE(4'h1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  // Registered memory behind dut_a.
  logic [15:0] mem_a [0:4095];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem_a[i] <= 16'h0000;
      bus_a.mem_read_data <= 16'h0000;
    end else begin
      if (bus_a.mem_read) bus_a.mem_read_data <= mem_a[bus_a.mem_address[11:0]];
      if (bus_a.mem_write) mem_a[bus_a.mem_address[11:0]] <= bus_a.mem_write_data;
    end
  end

  // Read-only pattern memory behind dut_b.
  always @(posedge clk) begin
    if (mem_clear) bus_b.mem_read_data <= 16'h0000;
    else if (bus_b.mem_read) bus_b.mem_read_data <= bus_b.mem_address ^ 16'h5A5A;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Mutual exclusion invariants, sampled mid-cycle.
  always @(negedge clk) begin
    check1("ack_excl_a", bus_a.ack0 & bus_a.ack1, 1'b0);
    check1("mem_excl_a", bus_a.mem_read & bus_a.mem_write, 1'b0);
    check1("ack_excl_b", bus_b.ack0 & bus_b.ack1, 1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.req0 = 1'b0; bus_a.we0 = 1'b0; bus_a.addr0 = 16'h0; bus_a.wdata0 = 16'h0;
    bus_a.req1 = 1'b0; bus_a.we1 = 1'b0; bus_a.addr1 = 16'h0; bus_a.wdata1 = 16'h0;
    bus_b.req0 = 1'b0; bus_b.we0 = 1'b0; bus_b.addr0 = 16'h0; bus_b.wdata0 = 16'h0;
    bus_b.req1 = 1'b0; bus_b.we1 = 1'b0; bus_b.addr1 = 16'h0; bus_b.wdata1 = 16'h0;
  endtask

  task automatic reset_duts();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_port(input int p, input logic req, input logic we,
                            input logic [15:0] addr, input logic [15:0] wdata);
    if (p == 0) begin
      bus_a.req0 = req; bus_a.we0 = we; bus_a.addr0 = addr; bus_a.wdata0 = wdata;
    end else begin
      bus_a.req1 = req; bus_a.we1 = we; bus_a.addr1 = addr; bus_a.wdata1 = wdata;
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? bus_a.ack0 : bus_a.ack1;
  endfunction

  // One isolated transaction on dut_a with cycle-exact latency checks.
  task automatic do_txn(input int p, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic exp_err,
                        input logic [15:0] exp_rdata);
    drive_port(p, 1'b1, we, addr, wdata);
    tick();
    if (!exp_err) begin
      check1("issue_rd", bus_a.mem_read, ~we);
      check1("issue_wr", bus_a.mem_write, we);
      check16("issue_addr", bus_a.mem_address, addr);
      if (we) check16("issue_wdata", bus_a.mem_write_data, wdata);
      check1("issue_busy", bus_a.busy, 1'b1);
      check1("issue_noack", ack_of(p), 1'b0);
      tick();
      check1("capture_nocmd", bus_a.mem_read | bus_a.mem_write, 1'b0);
      check1("capture_busy", bus_a.busy, 1'b1);
      check1("capture_noack", ack_of(p), 1'b0);
      tick();
    end else begin
      check1("illegal_nocmd", bus_a.mem_read | bus_a.mem_write, 1'b0);
    end
    check1("ack", ack_of(p), 1'b1);
    check1("ack_other", ack_of(1 - p), 1'b0);
    check1("ack_busy", bus_a.busy, 1'b1);
    check1("ack_err", (p == 0) ? bus_a.err0 : bus_a.err1, exp_err);
    check16("ack_rdata", (p == 0) ? bus_a.rdata0 : bus_a.rdata1, exp_rdata);
    drive_port(p, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    check1("post_ack", ack_of(p), 1'b0);
    check1("post_busy", bus_a.busy, 1'b0);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  logic [15:0] shadow [0:4095];

  task automatic make_req(output logic we, output logic [15:0] addr, output logic [15:0] wdata);
    logic [3:0]  nib;
    logic [11:0] low;
    we    = 1'($urandom_range(1, 0));
    wdata = 16'($urandom());
    if ($urandom_range(7, 0) == 0) begin
      nib  = 4'($urandom_range(15, 2));
      low  = 12'($urandom());
      addr = {nib, low};
    end else begin
      addr = 16'h1800 | 16'($urandom_range(15, 0));
    end
  endtask

  // Randomized traffic on dut_a checked against a transaction-timing model.
  task automatic random_phase(input int n);
    logic        pend [2];
    logic        pwe [2];
    logic [15:0] paddr [2];
    logic [15:0] pwdata [2];
    int          idle_at, grant_t, ack_at, serv, w;
    logic        lw, g_legal, g_we, e_err;
    logic [15:0] g_addr, e_rdata;
    int          ecnt;
    idle_at = 0; grant_t = -100; ack_at = -100; serv = 0; w = 0;
    lw = 1'b1; g_legal = 1'b0; g_we = 1'b0; e_err = 1'b0;
    g_addr = 16'h0; e_rdata = 16'h0; ecnt = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = 16'h0; pwdata[p] = 16'h0;
    end
    for (int t = 0; t < n; t++) begin
      drive_port(0, pend[0], pwe[0], paddr[0], pwdata[0]);
      drive_port(1, pend[1], pwe[1], paddr[1], pwdata[1]);
      if (t >= idle_at && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) w = lw ? 0 : 1;
        else w = pend[1] ? 1 : 0;
        lw      = (w == 1);
        serv    = w;
        grant_t = t;
        g_we    = pwe[w];
        g_addr  = paddr[w];
        g_legal = (g_addr[15:12] == 4'h1);
        if (g_legal) begin
          ack_at  = t + 2;
          idle_at = t + 4;
          e_err   = 1'b0;
          e_rdata = g_we ? 16'h0000 : shadow[g_addr[11:0]];
          if (g_we) shadow[g_addr[11:0]] = pwdata[w];
        end else begin
          ack_at  = t;
          idle_at = t + 2;
          e_err   = 1'b1;
          e_rdata = 16'h0000;
          if (ecnt < 255) ecnt++;
        end
      end
      tick();
      check1("rnd_ack0", bus_a.ack0, (t == ack_at) && (serv == 0));
      check1("rnd_ack1", bus_a.ack1, (t == ack_at) && (serv == 1));
      check1("rnd_busy", bus_a.busy, (t >= grant_t) && (t <= ack_at));
      check1("rnd_mem_rd", bus_a.mem_read, (t == grant_t) && g_legal && !g_we);
      check1("rnd_mem_wr", bus_a.mem_write, (t == grant_t) && g_legal && g_we);
      if (t == grant_t && g_legal) check16("rnd_mem_addr", bus_a.mem_address, g_addr);
      check8("rnd_err_count", bus_a.err_count, 8'(ecnt));
      if (t == ack_at) begin
        check1("rnd_err", (serv == 0) ? bus_a.err0 : bus_a.err1, e_err);
        check16("rnd_rdata", (serv == 0) ? bus_a.rdata0 : bus_a.rdata1, e_rdata);
      end
      for (int p = 0; p < 2; p++) begin
        if (t == ack_at && serv == p) begin
          pend[p] = 1'b0;
          if ($urandom_range(1, 0) == 1) begin
            make_req(pwe[p], paddr[p], pwdata[p]);
            pend[p] = 1'b1;
          end
        end else if (!pend[p] && $urandom_range(2, 0) == 0) begin
          make_req(pwe[p], paddr[p], pwdata[p]);
          pend[p] = 1'b1;
        end
      end
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  initial begin
    int acks;
    int k;
    logic saw_cmd;

    vecs[0] = '{0, 1'b1, 16'h1004, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1] = '{1, 1'b0, 16'h1004, 16'h0000, 1'b0, 16'hBEEF};
    vecs[2] = '{1, 1'b1, 16'h1FFE, 16'h1234, 1'b0, 16'h0000};
    vecs[3] = '{0, 1'b0, 16'h1FFE, 16'h0000, 1'b0, 16'h1234};
    vecs[4] = '{0, 1'b1, 16'h1000, 16'hAAAA, 1'b0, 16'h0000};
    vecs[5] = '{1, 1'b1, 16'h1001, 16'h5555, 1'b0, 16'h0000};
    vecs[6] = '{0, 1'b0, 16'h2000, 16'h0000, 1'b1, 16'h0000};
    vecs[7] = '{1, 1'b1, 16'h0FFF, 16'h7777, 1'b1, 16'h0000};
    vecs[8] = '{1, 1'b0, 16'h1000, 16'h0000, 1'b0, 16'hAAAA};

    for (int i = 0; i < 4096; i++) shadow[i] = 16'h0000;

    mem_clear = 1'b1;
    reset     = 1'b1;
    idle_inputs();
    tick();
    tick();
    mem_clear = 1'b0;

    // Reset state while reset is still asserted.
    check1("rst_ack0", bus_a.ack0, 1'b0);
    check1("rst_ack1", bus_a.ack1, 1'b0);
    check1("rst_err0", bus_a.err0, 1'b0);
    check1("rst_err1", bus_a.err1, 1'b0);
    check16("rst_rdata0", bus_a.rdata0, 16'h0);
    check16("rst_rdata1", bus_a.rdata1, 16'h0);
    check1("rst_mem_rd", bus_a.mem_read, 1'b0);
    check1("rst_mem_wr", bus_a.mem_write, 1'b0);
    check16("rst_mem_addr", bus_a.mem_address, 16'h0);
    check16("rst_mem_wdata", bus_a.mem_write_data, 16'h0);
    check1("rst_busy", bus_a.busy, 1'b0);
    check8("rst_err_count", bus_a.err_count, 8'h00);
    reset = 1'b0;
    tick();
    check1("idle_busy", bus_a.busy, 1'b0);

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_err, vecs[i].exp_rdata);
    end
    check8("table_err_count", bus_a.err_count, 8'd2);

    // Round-robin contention: strict alternation, each port every 8 cycles.
    reset_duts();
    drive_port(0, 1'b1, 1'b0, 16'h1000, 16'h0);
    drive_port(1, 1'b1, 1'b0, 16'h1001, 16'h0);
    for (int c = 1; c <= 32; c++) begin
      tick();
      check1("rr_ack0", bus_a.ack0, (c % 8) == 3);
      check1("rr_ack1", bus_a.ack1, (c % 8) == 7);
      if ((c % 8) == 3) check16("rr_rdata0", bus_a.rdata0, 16'hAAAA);
      if ((c % 8) == 7) check16("rr_rdata1", bus_a.rdata1, 16'h5555);
    end
    idle_inputs();
    repeat (4) tick();

    // Fixed priority contention on dut_b: port 0 every 4 cycles, port 1 starved.
    reset_duts();
    bus_b.req0 = 1'b1; bus_b.we0 = 1'b0; bus_b.addr0 = 16'h1010;
    bus_b.req1 = 1'b1; bus_b.we1 = 1'b0; bus_b.addr1 = 16'h1020;
    for (int c = 1; c <= 24; c++) begin
      tick();
      check1("fp_ack0", bus_b.ack0, (c % 4) == 3);
      check1("fp_ack1", bus_b.ack1, 1'b0);
      if ((c % 4) == 3) check16("fp_rdata0", bus_b.rdata0, 16'h1010 ^ 16'h5A5A);
    end
    idle_inputs();
    repeat (4) tick();

    // Illegal requests: N+1 ack with err, no memory command, saturating count.
    reset_duts();
    drive_port(0, 1'b1, 1'b0, 16'h2000, 16'h0);
    acks = 0;
    k = 0;
    saw_cmd = 1'b0;
    while (acks < 300 && k < 1000) begin
      tick();
      k++;
      if (bus_a.mem_read || bus_a.mem_write) saw_cmd = 1'b1;
      if (k == 1) begin
        check1("ill_first_ack", bus_a.ack0, 1'b1);
        check1("ill_first_err", bus_a.err0, 1'b1);
        check16("ill_first_rdata", bus_a.rdata0, 16'h0);
      end
      if (bus_a.ack0) begin
        acks++;
        check8("ill_err_count", bus_a.err_count, (acks > 255) ? 8'hFF : 8'(acks));
      end
    end
    check1("ill_timeout", acks == 300, 1'b1);
    check1("ill_no_mem_cmd", saw_cmd, 1'b0);
    check8("ill_saturated", bus_a.err_count, 8'hFF);
    idle_inputs();
    repeat (2) tick();

    // Reset during CAPTURE of a port-1 read.
    reset_duts();
    drive_port(1, 1'b1, 1'b0, 16'h1004, 16'h0);
    tick();
    check1("rc_issue_rd", bus_a.mem_read, 1'b1);
    tick();
    check1("rc_capture_busy", bus_a.busy, 1'b1);
    reset = 1'b1;
    drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    check1("rc_busy", bus_a.busy, 1'b0);
    check1("rc_ack1", bus_a.ack1, 1'b0);
    check1("rc_mem_rd", bus_a.mem_read, 1'b0);
    check1("rc_mem_wr", bus_a.mem_write, 1'b0);
    check16("rc_mem_addr", bus_a.mem_address, 16'h0);
    reset = 1'b0;
    tick();
    check1("rc_ack1_later", bus_a.ack1, 1'b0);
    tick();
    check1("rc_ack1_later2", bus_a.ack1, 1'b0);
    do_txn(0, 1'b0, 16'h1004, 16'h0, 1'b0, 16'hBEEF);

    // Randomized traffic against the reference model.
    reset_duts();
    random_phase(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-ported data memory interface (16-bit words, data window 0x1000-0x1FFF). It shares the memory between the CPU load/store unit (port 0) and the DMA/debug engine (port 1). It issues one-cycle read/write commands, captures the registered read data and returns a per-port acknowledge. Out-of-window requests are rejected without touching memory.

Parameters:
ROUND_ROBIN, 1, 1 = round-robin arbitration between ports; 0 = fixed priority with port 0 winning
DMEM_NIBBLE, 4'h1, required value of address[15:12] for an access to be legal

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
req0  input  1  port 0 (CPU) request, held until ack0
we0  input  1  port 0 write enable (1 = write, 0 = read)
addr0  input  16  port 0 byte/word address
wdata0  input  16  port 0 write data
ack0  output  1  port 0 one-cycle acknowledge
rdata0  output  16  port 0 read data, valid while ack0=1
err0  output  1  port 0 address error, valid while ack0=1
req1, we1, addr1, wdata1, ack1, rdata1, err1  same directions and widths as port 0, for port 1 (DMA)
mem_read  output  1  to memory interface
mem_write  output  1  to memory interface
mem_address  output  16  to memory interface
mem_write_data  output  16  to memory interface
mem_read_data  input  16  from memory interface; registered, valid the cycle after mem_read
busy  output  1  1 whenever state != IDLE
err_count  output  8  saturating count of rejected requests

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high (reset sampled on posedge clk).
- Reset values: state=IDLE; last_grant=1, so port 0 wins the first tie. All outputs are 0: ack*, err*, rdata*, mem_*, busy, err_count.
- Reset mid-transaction: the block returns to IDLE, any pending ack is dropped, and memory contents are untouched.
- States: IDLE, ISSUE, CAPTURE, ACK.
- IDLE: if neither req is high, stay in IDLE. Otherwise grant one port:
  - fixed priority: port 0 wins;
  - round-robin, both requesting: the port not equal to last_grant wins;
  - single requester: that port wins.
  On grant, register gnt, we, addr and wdata, and update last_grant.
  - Legal address (addr[15:12]==DMEM_NIBBLE): go to ISSUE.
  - Illegal address: go to ACK with err=1 and rdata=0; err_count increments, saturating at 255.
- ISSUE, exactly 1 cycle:
  - mem_read = !we, mem_write = we;
  - mem_address = latched addr, mem_write_data = latched wdata;
  - all mem_* return to 0 on exit.
  - Next state: CAPTURE.
- CAPTURE: register mem_read_data into the granted port's rdata; for writes, register 0 instead. Next state: ACK.
- ACK, exactly 1 cycle:
  - the granted port's ack=1; its rdata and err are held stable;
  - the other port's ack=0;
  - no new grant is made in this cycle.
  - Next state: IDLE.
- Latency: req sampled high in IDLE at cycle N gives ack in cycle N+3 for a legal access, or N+1 for an illegal access.
- Back-to-back throughput: one legal transaction per 4 cycles.
- Requester rules:
  - req, we, addr and wdata are held stable until ack.
  - In the cycle after ack, the requester may keep req high to present a new request; it is then eligible in IDLE.
  - Inputs of the granted port are ignored after the grant (they are latched).
- rdata and err of a port are undefined-but-stable outside its ack cycle; they are driven by the last value written.
- Simultaneous requests under round-robin alternate strictly: 0,1,0,1...
- Only one of ack0/ack1 is ever high, and mem_read and mem_write are never high together.

Test Plan:
- Reset, then write from port 0: req0=1, we0=1, addr0=16'h1004, wdata0=16'hBEEF -> mem_write=1 with mem_address=16'h1004 in cycle N+1; ack0=1 in cycle N+3 with err0=0; busy=1 in cycles N+1..N+3.
- Read back on port 1: req1=1, we1=0, addr1=16'h1004 -> mem_read=1 in cycle N+1; ack1=1 in cycle N+3 with rdata1=16'hBEEF.
- Contention, round-robin: req0 and req1 held high continuously, reading 0x1000 and 0x1001 -> grant order 0,1,0,1; ack0 and ack1 each arrive every 8 cycles; the two acks are never both high.
- Contention with ROUND_ROBIN=0: both requests held high -> port 0 is acknowledged every 4 cycles and port 1 is never served.
- Illegal address: req0=1, addr0=16'h2000 -> ack0 in cycle N+1 with err0=1 and rdata0=0; no mem_read or mem_write pulse; err_count=1. After 300 illegal requests, err_count=255.
- Reset asserted during CAPTURE of a port-1 read -> next cycle state=IDLE; ack1 never pulses; all mem_* are 0; a following port-0 request completes with normal N+3 latency.
